// File: rtl/crc_gen.sv
// crc_gen: word-parallel, non-augmented, MSB-first CRC generator with a
// valid/ready handshake on both the data side and the result side.
// Optional checker mode is enabled by defining CRC_GEN_CHECK_EN, which adds
// the CRC_Exp input and the CRC_Err output.
module crc_gen #(
  parameter int              CRC_W   = 10,
  parameter logic [CRC_W-1:0] POLY   = 10'h233,
  parameter int              DATA_W  = 32,
  parameter logic [CRC_W-1:0] INIT   = '0,
  parameter logic [CRC_W-1:0] XOR_OUT = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              CRC_Clr,
  input  logic [DATA_W-1:0] Data_In,
  input  logic              Data_Valid,
  input  logic              Data_Last,
  output logic              Data_Ready,
  output logic [CRC_W-1:0]  CRC_Out,
  output logic              CRC_Valid,
`ifdef CRC_GEN_CHECK_EN
  input  logic [CRC_W-1:0]  CRC_Exp,
  output logic              CRC_Err,
`endif
  input  logic              CRC_Ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic [CRC_W-1:0]   crc_out_q, crc_out_d;
  logic               crc_valid_q, crc_valid_d;
  logic               data_ready_q, data_ready_d;

  // One full word through the bit-serial CRC recurrence, unrolled in time.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c_in,
                                                input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = c_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ d[i];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  logic [CRC_W-1:0] crc_base;
  logic [CRC_W-1:0] crc_word;

  // The first word of a frame starts from INIT rather than the stale register.
  always_comb begin
    crc_base = (state_q == IDLE) ? INIT : crc_q;
    crc_word = crc_step(crc_base, Data_In);
  end

  // Next-state, next-CRC and registered output values.
  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    crc_out_d    = crc_out_q;
    crc_valid_d  = crc_valid_q;
    data_ready_d = data_ready_q;
    if (CRC_Clr) begin
      // Abort wins over any word presented in the same cycle.
      state_d      = IDLE;
      crc_d        = INIT;
      crc_out_d    = '0;
      crc_valid_d  = 1'b0;
      data_ready_d = 1'b1;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (Data_Valid) begin
            crc_d = crc_word;
            if (Data_Last) begin
              state_d      = DONE;
              crc_out_d    = crc_word ^ XOR_OUT;
              crc_valid_d  = 1'b1;
              data_ready_d = 1'b0;
            end else begin
              state_d = ACCUM;
            end
          end
        end
        DONE: begin
          if (CRC_Ready) begin
            state_d      = IDLE;
            crc_out_d    = '0;
            crc_valid_d  = 1'b0;
            data_ready_d = 1'b1;
          end
        end
        default: begin
          state_d      = IDLE;
          crc_d        = INIT;
          crc_out_d    = '0;
          crc_valid_d  = 1'b0;
          data_ready_d = 1'b1;
        end
      endcase
    end
  end

  // State and registered outputs; Reset overrides everything including CRC_Clr.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= IDLE;
      crc_q        <= INIT;
      crc_out_q    <= '0;
      crc_valid_q  <= 1'b0;
      data_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      crc_out_q    <= crc_out_d;
      crc_valid_q  <= crc_valid_d;
      data_ready_q <= data_ready_d;
    end
  end

  assign Data_Ready = data_ready_q;
  assign CRC_Valid  = crc_valid_q;
  assign CRC_Out    = crc_out_q;

`ifdef CRC_GEN_CHECK_EN
  // Compare against the expected value only while a result is being offered.
  assign CRC_Err = crc_valid_q && (crc_out_q != CRC_Exp);
`endif

endmodule

// File: tb/tb_crc_gen.sv
// Self-checking bench for crc_gen with default parameters.
// Reference: augmented polynomial long division over the whole frame.
module tb_crc_gen;

  localparam int             CW   = 10;
  localparam int             DW   = 32;
  localparam logic [CW-1:0]  POLY = 10'h233;
  localparam logic [CW-1:0]  INIT = '0;
  localparam logic [CW-1:0]  XOUT = '0;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          CRC_Clr = 1'b0;
  logic [DW-1:0] Data_In = '0;
  logic          Data_Valid = 1'b0;
  logic          Data_Last = 1'b0;
  logic          Data_Ready;
  logic [CW-1:0] CRC_Out;
  logic          CRC_Valid;
  logic          CRC_Ready = 1'b0;
`ifdef CRC_GEN_CHECK_EN
  logic [CW-1:0] CRC_Exp = '0;
  logic          CRC_Err;
`endif

  int checks = 0;
  int errors = 0;

  crc_gen #(.CRC_W(CW), .POLY(POLY), .DATA_W(DW), .INIT(INIT), .XOR_OUT(XOUT)) dut (
    .Clock(Clock), .Reset(Reset), .CRC_Clr(CRC_Clr),
    .Data_In(Data_In), .Data_Valid(Data_Valid), .Data_Last(Data_Last),
    .Data_Ready(Data_Ready), .CRC_Out(CRC_Out), .CRC_Valid(CRC_Valid),
`ifdef CRC_GEN_CHECK_EN
    .CRC_Exp(CRC_Exp), .CRC_Err(CRC_Err),
`endif
    .CRC_Ready(CRC_Ready)
  );

  always #5 Clock = ~Clock;

  // Remainder of (INIT*x^N + M(x)) * x^W divided by x^W + POLY.
  function automatic logic [CW-1:0] ref_crc(input logic [DW-1:0] words[$]);
    logic  bits[$];
    logic [CW:0] rem;
    logic [DW-1:0] w;
    bits = {};
    foreach (words[k]) begin
      w = words[k];
      for (int i = DW - 1; i >= 0; i--) bits.push_back(w[i]);
    end
    for (int i = 0; i < CW; i++) bits.push_back(1'b0);
    for (int i = 0; i < CW; i++) bits[i] = bits[i] ^ INIT[CW-1-i];
    rem = '0;
    foreach (bits[k]) begin
      rem = {rem[CW-1:0], bits[k]};
      if (rem[CW]) rem = rem ^ {1'b1, POLY};
    end
    return rem[CW-1:0] ^ XOUT;
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic last);
    Data_In = d; Data_Last = last; Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0; Data_Last = 1'b0;
  endtask

  task automatic release_crc();
    CRC_Ready = 1'b1;
    tick();
    CRC_Ready = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    checks++;
    if (Data_Ready !== 1'b1 || CRC_Valid !== 1'b0 || CRC_Out !== '0) begin
      errors++;
      $display("FAIL reset: ready=%b valid=%b out=%h required ready=1 valid=0 out=000",
               Data_Ready, CRC_Valid, CRC_Out);
    end
    $display("test_reset ready=%b valid=%b out=%h", Data_Ready, CRC_Valid, CRC_Out);
  endtask

  task automatic test_single_word();
    send_word(32'h0000_0001, 1'b1);
    checks++;
    if (CRC_Valid !== 1'b1 || CRC_Out !== 10'h233) begin
      errors++;
      $display("FAIL single_word: valid=%b out=%h required valid=1 out=233", CRC_Valid, CRC_Out);
    end
    $display("test_single_word out=%h", CRC_Out);
    release_crc();
    checks++;
    if (CRC_Valid !== 1'b0 || CRC_Out !== '0 || Data_Ready !== 1'b1) begin
      errors++;
      $display("FAIL single_release: valid=%b out=%h ready=%b required 0/000/1",
               CRC_Valid, CRC_Out, Data_Ready);
    end
  endtask

  task automatic test_hold();
    send_word(32'h0000_0002, 1'b1);
    for (int c = 0; c < 5; c++) begin
      // Offer a word while DONE; it must be ignored.
      Data_In = $urandom; Data_Valid = 1'b1; Data_Last = 1'b1;
      checks++;
      if (CRC_Valid !== 1'b1 || CRC_Out !== 10'h255 || Data_Ready !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle %0d: valid=%b out=%h ready=%b required 1/255/0",
                 c, CRC_Valid, CRC_Out, Data_Ready);
      end
      tick();
    end
    Data_Valid = 1'b0; Data_Last = 1'b0;
    $display("test_hold out=%h", CRC_Out);
    release_crc();
    checks++;
    if (CRC_Valid !== 1'b0 || CRC_Out !== '0) begin
      errors++;
      $display("FAIL hold_release: valid=%b out=%h required 0/000", CRC_Valid, CRC_Out);
    end
  endtask

  task automatic test_back_to_back();
    send_word(32'h0, 1'b0);
    send_word(32'h0, 1'b1);
    checks++;
    if (CRC_Valid !== 1'b1 || CRC_Out !== 10'h000) begin
      errors++;
      $display("FAIL b2b_first: valid=%b out=%h required 1/000", CRC_Valid, CRC_Out);
    end
    release_crc();
    send_word(32'h1, 1'b1);
    checks++;
    if (CRC_Valid !== 1'b1 || CRC_Out !== 10'h233) begin
      errors++;
      $display("FAIL b2b_second: valid=%b out=%h required 1/233", CRC_Valid, CRC_Out);
    end
    $display("test_back_to_back second=%h", CRC_Out);
    release_crc();
  endtask

  task automatic test_clear();
    send_word(32'hFFFF_FFFF, 1'b0);
    CRC_Clr = 1'b1; Data_Valid = 1'b1; Data_Last = 1'b1; Data_In = 32'h1234_5678;
    tick();
    CRC_Clr = 1'b0; Data_Valid = 1'b0; Data_Last = 1'b0;
    checks++;
    if (CRC_Valid !== 1'b0 || Data_Ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_discard: valid=%b ready=%b required 0/1", CRC_Valid, Data_Ready);
    end
    send_word(32'h1, 1'b1);
    checks++;
    if (CRC_Valid !== 1'b1 || CRC_Out !== 10'h233) begin
      errors++;
      $display("FAIL clear_frame: valid=%b out=%h required 1/233", CRC_Valid, CRC_Out);
    end
    // Clear also aborts DONE.
    CRC_Clr = 1'b1;
    tick();
    CRC_Clr = 1'b0;
    checks++;
    if (CRC_Valid !== 1'b0 || CRC_Out !== '0 || Data_Ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_done: valid=%b out=%h ready=%b required 0/000/1",
               CRC_Valid, CRC_Out, Data_Ready);
    end
    $display("test_clear done");
  endtask

  task automatic test_reset_mid();
    send_word(32'hA5A5_0F0F, 1'b0);
    Reset = 1'b1; CRC_Clr = 1'b1; Data_Valid = 1'b1; Data_Last = 1'b1; Data_In = 32'h1;
    tick();
    Reset = 1'b0; CRC_Clr = 1'b0; Data_Valid = 1'b0; Data_Last = 1'b0;
    checks++;
    if (CRC_Valid !== 1'b0 || Data_Ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_accum: valid=%b ready=%b required 0/1", CRC_Valid, Data_Ready);
    end
    send_word(32'h1, 1'b1);
    checks++;
    if (CRC_Out !== 10'h233 || CRC_Valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_accum_frame: valid=%b out=%h required 1/233", CRC_Valid, CRC_Out);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if (CRC_Valid !== 1'b0 || Data_Ready !== 1'b1 || CRC_Out !== '0) begin
      errors++;
      $display("FAIL reset_done: valid=%b ready=%b out=%h required 0/1/000",
               CRC_Valid, Data_Ready, CRC_Out);
    end
    send_word(32'h1, 1'b1);
    checks++;
    if (CRC_Out !== 10'h233 || CRC_Valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_done_frame: valid=%b out=%h required 1/233", CRC_Valid, CRC_Out);
    end
    release_crc();
    $display("test_reset_mid done");
  endtask

`ifdef CRC_GEN_CHECK_EN
  task automatic test_checker();
    send_word(32'h1, 1'b1);
    CRC_Exp = 10'h233;
    #1;
    checks++;
    if (CRC_Err !== 1'b0) begin
      errors++;
      $display("FAIL checker_match: err=%b required 0", CRC_Err);
    end
    CRC_Exp = 10'h232;
    #1;
    checks++;
    if (CRC_Err !== 1'b1) begin
      errors++;
      $display("FAIL checker_mismatch: err=%b required 1", CRC_Err);
    end
    release_crc();
    checks++;
    if (CRC_Err !== 1'b0) begin
      errors++;
      $display("FAIL checker_idle: err=%b required 0", CRC_Err);
    end
    $display("test_checker done");
  endtask
`endif

  task automatic test_random_frames();
    logic [DW-1:0] frame[$];
    logic [CW-1:0] exp_crc;
    int len;
    int budget;
    for (int f = 0; f < 40; f++) begin
      frame = {};
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        frame.push_back($urandom);
        // Random idle gaps inside the frame.
        repeat ($urandom_range(0, 2)) tick();
        checks++;
        if (Data_Ready !== 1'b1) begin
          errors++;
          $display("FAIL rand_ready f=%0d w=%0d: ready=%b required 1", f, k, Data_Ready);
        end
        send_word(frame[k], (k == len - 1));
      end
      exp_crc = ref_crc(frame);
      checks++;
      if (CRC_Valid !== 1'b1 || CRC_Out !== exp_crc) begin
        errors++;
        $display("FAIL rand_crc f=%0d len=%0d: valid=%b out=%h required 1/%h",
                 f, len, CRC_Valid, CRC_Out, exp_crc);
      end
      $display("frame %0d len=%0d crc=%h exp=%h", f, len, CRC_Out, exp_crc);
      repeat ($urandom_range(0, 3)) tick();
      budget = 0;
      CRC_Ready = 1'b1;
      while (CRC_Valid === 1'b1 && budget < 10) begin
        tick();
        budget++;
      end
      CRC_Ready = 1'b0;
      checks++;
      if (CRC_Valid !== 1'b0 || CRC_Out !== '0) begin
        errors++;
        $display("FAIL rand_release f=%0d: valid=%b out=%h required 0/000", f, CRC_Valid, CRC_Out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_hold();
    test_back_to_back();
    test_clear();
    test_reset_mid();
`ifdef CRC_GEN_CHECK_EN
    test_checker();
`endif
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
